// File: rtl/wb_arbiter2.sv
// Two-master, one-slave Wishbone classic arbiter with round-robin ownership
// held for a whole CYC and a stall watchdog that terminates hung strobes with ERR.
module wb_arbiter2 #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        sys_clk_i,
    input  logic        sys_rst_i,

    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [15:0] m0_adr_i,
    input  logic [15:0] m0_dat_i,
    output logic [15:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,

    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [15:0] m1_adr_i,
    input  logic [15:0] m1_dat_i,
    output logic [15:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,

    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [15:0] s_adr_o,
    output logic [15:0] s_dat_o,
    input  logic [15:0] s_dat_i,
    input  logic        s_ack_i,
    input  logic        s_err_i,

    output logic [1:0]  gnt_o,
    output logic        timeout_o
);

    generate
        if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
            $error("wb_arbiter2: TIMEOUT must be in 2..65535");
        end
    endgenerate

    localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        OWN0,
        OWN1,
        ABORT
    } state_t;

    state_t      state;
    logic        owner;
    logic [15:0] wd_cnt;

    logic        own_cyc;
    logic        own_stb;
    logic        owning;
    logic        stalled;

    // 'owner' is updated at grant time rather than at release; since ties are
    // only resolved in IDLE after the owner has left, it doubles as last-owner.
    always_comb begin
        own_cyc = owner ? m1_cyc_i : m0_cyc_i;
        own_stb = owner ? m1_stb_i : m0_stb_i;
        owning  = (state == OWN0) || (state == OWN1);
        stalled = own_stb && !s_ack_i && !s_err_i;
    end

    always_comb begin
        s_cyc_o  = owning && own_cyc;
        s_stb_o  = owning && own_stb;
        s_we_o   = owner ? m1_we_i  : m0_we_i;
        s_adr_o  = owner ? m1_adr_i : m0_adr_i;
        s_dat_o  = owner ? m1_dat_i : m0_dat_i;

        m0_dat_o = s_dat_i;
        m1_dat_o = s_dat_i;
        m0_ack_o = (state == OWN0) && s_ack_i;
        m1_ack_o = (state == OWN1) && s_ack_i;
        m0_err_o = ((state == OWN0) && s_err_i) || ((state == ABORT) && !owner);
        m1_err_o = ((state == OWN1) && s_err_i) || ((state == ABORT) && owner);
    end

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            state     <= IDLE;
            owner     <= 1'b1;
            wd_cnt    <= '0;
            gnt_o     <= '0;
            timeout_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    wd_cnt <= '0;
                    if (m0_cyc_i && (!m1_cyc_i || owner)) begin
                        state <= OWN0;
                        owner <= 1'b0;
                        gnt_o <= 2'b01;
                    end else if (m1_cyc_i) begin
                        state <= OWN1;
                        owner <= 1'b1;
                        gnt_o <= 2'b10;
                    end
                end
                OWN0, OWN1: begin
                    if (!own_cyc) begin
                        state  <= IDLE;
                        gnt_o  <= '0;
                        wd_cnt <= '0;
                    end else if (stalled) begin
                        if (wd_cnt == WD_LAST) begin
                            state     <= ABORT;
                            wd_cnt    <= '0;
                            timeout_o <= 1'b1;
                        end else begin
                            wd_cnt <= wd_cnt + 16'd1;
                        end
                    end else begin
                        wd_cnt <= '0;
                    end
                end
                ABORT: begin
                    wd_cnt <= '0;
                    if (own_cyc) begin
                        state <= owner ? OWN1 : OWN0;
                    end else begin
                        state <= IDLE;
                        gnt_o <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt_o <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Self-checking bench for wb_arbiter2: directed scenarios plus randomized traffic
// compared against an ownership/stall-count reference model.
module tb_wb_arbiter2;

    localparam int TB_TIMEOUT = 8;

    logic        clk = 1'b0;
    bit          clk_run = 1'b1;
    logic        rst;

    logic        m0_cyc_i, m0_stb_i, m0_we_i;
    logic [15:0] m0_adr_i, m0_dat_i, m0_dat_o;
    logic        m0_ack_o, m0_err_o;
    logic        m1_cyc_i, m1_stb_i, m1_we_i;
    logic [15:0] m1_adr_i, m1_dat_i, m1_dat_o;
    logic        m1_ack_o, m1_err_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [15:0] s_adr_o, s_dat_o, s_dat_i;
    logic        s_ack_i, s_err_i;
    logic [1:0]  gnt_o;
    logic        timeout_o;

    int checks = 0;
    int failures = 0;

    wb_arbiter2 #(.TIMEOUT(TB_TIMEOUT)) dut (
        .sys_clk_i(clk),      .sys_rst_i(rst),
        .m0_cyc_i(m0_cyc_i),  .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
        .m0_adr_i(m0_adr_i),  .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o),
        .m0_ack_o(m0_ack_o),  .m0_err_o(m0_err_o),
        .m1_cyc_i(m1_cyc_i),  .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
        .m1_adr_i(m1_adr_i),  .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o),
        .m1_ack_o(m1_ack_o),  .m1_err_o(m1_err_o),
        .s_cyc_o(s_cyc_o),    .s_stb_o(s_stb_o),   .s_we_o(s_we_o),
        .s_adr_o(s_adr_o),    .s_dat_o(s_dat_o),   .s_dat_i(s_dat_i),
        .s_ack_i(s_ack_i),    .s_err_i(s_err_i),
        .gnt_o(gnt_o),        .timeout_o(timeout_o)
    );

    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL global_time_limit: simulation did not finish, required finish before 2000000");
        $fatal(1);
    end

    // Reference model: who owns the bus, whether the one-cycle abort is in
    // progress, and how many consecutive stalled strobes have been seen.
    int mdl_cur;     // -1 idle, else owning master index
    int mdl_last;
    int mdl_stall;
    bit mdl_abort;
    bit mdl_to;

    function automatic logic req(input int i);
        return (i == 0) ? m0_cyc_i : m1_cyc_i;
    endfunction

    function automatic logic strobe(input int i);
        return (i == 0) ? m0_stb_i : m1_stb_i;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mdl_cur <= -1; mdl_last <= 1; mdl_stall <= 0; mdl_abort <= 1'b0; mdl_to <= 1'b0;
        end else if (mdl_abort) begin
            mdl_abort <= 1'b0;
            mdl_stall <= 0;
            if (!req(mdl_cur)) begin
                mdl_last <= mdl_cur;
                mdl_cur  <= -1;
            end
        end else if (mdl_cur < 0) begin
            if (m0_cyc_i && m1_cyc_i) mdl_cur <= 1 - mdl_last;
            else if (m0_cyc_i)        mdl_cur <= 0;
            else if (m1_cyc_i)        mdl_cur <= 1;
        end else if (!req(mdl_cur)) begin
            mdl_last  <= mdl_cur;
            mdl_cur   <= -1;
            mdl_stall <= 0;
        end else if (strobe(mdl_cur) && !s_ack_i && !s_err_i) begin
            if (mdl_stall + 1 == TB_TIMEOUT) begin
                mdl_abort <= 1'b1;
                mdl_to    <= 1'b1;
                mdl_stall <= 0;
            end else begin
                mdl_stall <= mdl_stall + 1;
            end
        end else begin
            mdl_stall <= 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_adr_i = '0; m0_dat_i = '0;
        m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_adr_i = '0; m1_dat_i = '0;
        s_dat_i = '0; s_ack_i = 0; s_err_i = 0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        #1;
        checks++; if (gnt_o !== 2'b00) begin failures++; $display("FAIL reset_gnt: got %b want 00", gnt_o); end
        checks++; if ({s_cyc_o, s_stb_o} !== 2'b00) begin failures++; $display("FAIL reset_slave: cyc/stb got %b want 00", {s_cyc_o, s_stb_o}); end
        checks++; if (timeout_o !== 1'b0) begin failures++; $display("FAIL reset_timeout: got %b want 0", timeout_o); end
        checks++; if ({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o} !== 4'b0000) begin
            failures++; $display("FAIL reset_master_resp: got %b want 0000", {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_master();
        m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 0; m0_adr_i = 16'h4000;
        #1;
        checks++; if (gnt_o !== 2'b00 || s_stb_o !== 1'b0) begin failures++; $display("FAIL single_pre_grant: gnt/stb got %b/%b want 00/0", gnt_o, s_stb_o); end
        tick(); #1;
        checks++; if (gnt_o !== 2'b01) begin failures++; $display("FAIL single_gnt: got %b want 01", gnt_o); end
        checks++; if ({s_cyc_o, s_stb_o, s_we_o} !== 3'b110 || s_adr_o !== 16'h4000) begin
            failures++; $display("FAIL single_slave_req: cyc/stb/we=%b adr=%h want 110 4000", {s_cyc_o, s_stb_o, s_we_o}, s_adr_o);
        end
        checks++; if (m0_ack_o !== 1'b0) begin failures++; $display("FAIL single_wait1: ack got %b want 0", m0_ack_o); end
        tick(); #1;
        checks++; if (m0_ack_o !== 1'b0 || s_stb_o !== 1'b1) begin failures++; $display("FAIL single_wait2: ack/stb got %b/%b want 0/1", m0_ack_o, s_stb_o); end
        s_ack_i = 1; s_dat_i = 16'hBEEF;
        #1;
        checks++; if (m0_ack_o !== 1'b1 || m0_dat_o !== 16'hBEEF) begin failures++; $display("FAIL single_read: ack=%b dat=%h want 1 beef", m0_ack_o, m0_dat_o); end
        checks++; if (m1_ack_o !== 1'b0) begin failures++; $display("FAIL single_other_ack: got %b want 0", m1_ack_o); end
        tick();
        m0_cyc_i = 0; m0_stb_i = 0; s_ack_i = 0;
        #1;
        checks++; if (gnt_o !== 2'b01 || s_cyc_o !== 1'b0) begin failures++; $display("FAIL single_drop: gnt/cyc got %b/%b want 01/0", gnt_o, s_cyc_o); end
        tick(); #1;
        checks++; if (gnt_o !== 2'b00) begin failures++; $display("FAIL single_release: gnt got %b want 00", gnt_o); end
    endtask

    task automatic test_round_robin();
        idle_inputs();
        pulse_reset();
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 16'h1000;
        m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 16'h2000;
        #1;
        checks++; if (gnt_o !== 2'b00) begin failures++; $display("FAIL rr_pre: gnt got %b want 00", gnt_o); end
        tick(); #1;
        checks++; if (gnt_o !== 2'b01 || s_adr_o !== 16'h1000) begin failures++; $display("FAIL rr_first_m0: gnt=%b adr=%h want 01 1000", gnt_o, s_adr_o); end
        s_ack_i = 1; #1;
        checks++; if ({m0_ack_o, m1_ack_o} !== 2'b10) begin failures++; $display("FAIL rr_ack_m0: m0/m1 ack %b want 10", {m0_ack_o, m1_ack_o}); end
        tick();
        m0_cyc_i = 0; m0_stb_i = 0; s_ack_i = 0;
        tick();
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 16'h1002;
        #1;
        checks++; if (gnt_o !== 2'b00 || s_cyc_o !== 1'b0) begin failures++; $display("FAIL rr_idle_gap: gnt/cyc %b/%b want 00/0", gnt_o, s_cyc_o); end
        tick(); #1;
        checks++; if (gnt_o !== 2'b10 || s_adr_o !== 16'h2000) begin failures++; $display("FAIL rr_second_m1: gnt=%b adr=%h want 10 2000", gnt_o, s_adr_o); end
        s_ack_i = 1; #1;
        checks++; if ({m0_ack_o, m1_ack_o} !== 2'b01) begin failures++; $display("FAIL rr_ack_m1: m0/m1 ack %b want 01", {m0_ack_o, m1_ack_o}); end
        tick();
        m1_cyc_i = 0; m1_stb_i = 0; s_ack_i = 0;
        tick(); #1;
        checks++; if (gnt_o !== 2'b00) begin failures++; $display("FAIL rr_idle_gap2: gnt %b want 00", gnt_o); end
        tick(); #1;
        checks++; if (gnt_o !== 2'b01 || s_adr_o !== 16'h1002) begin failures++; $display("FAIL rr_third_m0: gnt=%b adr=%h want 01 1002", gnt_o, s_adr_o); end
        s_ack_i = 1;
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_block_hold();
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 16'h0300;
        m1_cyc_i = 1; m1_stb_i = 0;
        tick(); #1;
        checks++; if (gnt_o !== 2'b10) begin failures++; $display("FAIL block_grant: gnt %b want 10", gnt_o); end
        for (int k = 0; k < 4; k++) begin
            if (k == 2) begin
                m1_stb_i = 0;
                #1;
                checks++; if (gnt_o !== 2'b10 || s_stb_o !== 1'b0) begin failures++; $display("FAIL block_gap: gnt/stb %b/%b want 10/0", gnt_o, s_stb_o); end
                tick();
            end
            m1_stb_i = 1; m1_we_i = 1; m1_adr_i = 16'h5000 + 16'(k); m1_dat_i = 16'h1111 * 16'(k + 1);
            s_ack_i = 1;
            #1;
            checks++; if (s_adr_o !== 16'h5000 + 16'(k) || s_dat_o !== 16'h1111 * 16'(k + 1) || s_we_o !== 1'b1) begin
                failures++; $display("FAIL block_beat%0d: adr=%h dat=%h we=%b want %h %h 1", k, s_adr_o, s_dat_o, s_we_o, 16'h5000 + 16'(k), 16'h1111 * 16'(k + 1));
            end
            checks++; if ({m0_ack_o, m1_ack_o} !== 2'b01 || gnt_o !== 2'b10) begin
                failures++; $display("FAIL block_ack%0d: m0/m1 ack %b gnt %b want 01 10", k, {m0_ack_o, m1_ack_o}, gnt_o);
            end
            tick();
            s_ack_i = 0;
        end
        m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0;
        tick(); #1;
        checks++; if (gnt_o !== 2'b00) begin failures++; $display("FAIL block_release: gnt %b want 00", gnt_o); end
        tick(); #1;
        checks++; if (gnt_o !== 2'b01 || s_adr_o !== 16'h0300) begin failures++; $display("FAIL block_m0_after: gnt=%b adr=%h want 01 0300", gnt_o, s_adr_o); end
        s_ack_i = 1;
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_error_passthrough();
        m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 0; m1_adr_i = 16'h6000;
        tick(); #1;
        checks++; if (gnt_o !== 2'b10) begin failures++; $display("FAIL err_grant: gnt %b want 10", gnt_o); end
        s_err_i = 1; #1;
        checks++; if ({m1_err_o, m1_ack_o} !== 2'b10) begin failures++; $display("FAIL err_m1: err/ack %b want 10", {m1_err_o, m1_ack_o}); end
        checks++; if ({m0_err_o, m0_ack_o} !== 2'b00) begin failures++; $display("FAIL err_m0_quiet: err/ack %b want 00", {m0_err_o, m0_ack_o}); end
        tick();
        s_ack_i = 1; s_err_i = 1; #1;
        checks++; if ({m1_ack_o, m1_err_o} !== 2'b11) begin failures++; $display("FAIL err_ack_both: ack/err %b want 11", {m1_ack_o, m1_err_o}); end
        tick();
        idle_inputs();
        tick(); #1;
        checks++; if (timeout_o !== 1'b0 || gnt_o !== 2'b00) begin failures++; $display("FAIL err_no_timeout: timeout=%b gnt=%b want 0 00", timeout_o, gnt_o); end
    endtask

    task automatic test_watchdog();
        m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1; m0_adr_i = 16'h7000; m0_dat_i = 16'h1234;
        tick();
        for (int k = 0; k < TB_TIMEOUT; k++) begin
            #1;
            checks++; if (s_stb_o !== 1'b1 || m0_err_o !== 1'b0) begin failures++; $display("FAIL wd_stall%0d: stb/err %b/%b want 1/0", k, s_stb_o, m0_err_o); end
            tick();
        end
        #1;
        checks++; if ({s_cyc_o, s_stb_o} !== 2'b00 || m0_err_o !== 1'b1) begin
            failures++; $display("FAIL wd_abort: cyc/stb %b err %b want 00 1", {s_cyc_o, s_stb_o}, m0_err_o);
        end
        checks++; if (timeout_o !== 1'b1) begin failures++; $display("FAIL wd_flag: timeout %b want 1", timeout_o); end
        s_ack_i = 1; #1;
        checks++; if (m0_ack_o !== 1'b0) begin failures++; $display("FAIL wd_late_ack: m0_ack %b want 0", m0_ack_o); end
        tick();
        s_ack_i = 0; #1;
        checks++; if (m0_err_o !== 1'b0 || s_stb_o !== 1'b1) begin failures++; $display("FAIL wd_after_abort: err/stb %b/%b want 0/1", m0_err_o, s_stb_o); end
        idle_inputs();
        tick(); #1;
        checks++; if (timeout_o !== 1'b1 || gnt_o !== 2'b00) begin failures++; $display("FAIL wd_sticky: timeout=%b gnt=%b want 1 00", timeout_o, gnt_o); end
    endtask

    task automatic test_async_reset();
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 16'h0042;
        tick(); #1;
        checks++; if (s_cyc_o !== 1'b1 || gnt_o !== 2'b01) begin failures++; $display("FAIL arst_setup: cyc/gnt %b/%b want 1/01", s_cyc_o, gnt_o); end
        clk_run = 1'b0;
        #30;
        rst = 1'b1;
        #1;
        checks++; if ({s_cyc_o, s_stb_o} !== 2'b00 || gnt_o !== 2'b00 || timeout_o !== 1'b0 || m0_err_o !== 1'b0) begin
            failures++; $display("FAIL arst_immediate: cyc/stb=%b gnt=%b timeout=%b err=%b want 00 00 0 0", {s_cyc_o, s_stb_o}, gnt_o, timeout_o, m0_err_o);
        end
        rst = 1'b0;
        m1_cyc_i = 1; m1_stb_i = 1;
        #1;
        clk_run = 1'b1;
        @(negedge clk); #1;
        checks++; if (gnt_o !== 2'b01) begin failures++; $display("FAIL arst_tie: gnt %b want 01", gnt_o); end
        idle_inputs();
        tick();
        tick();
    endtask

    task automatic test_random();
        int ack_pct;
        logic [8:0] exp_v, act_v;
        bit own;
        idle_inputs();
        pulse_reset();
        ack_pct = 30;
        for (int n = 0; n < 3000; n++) begin
            if (n % 250 == 0) ack_pct = ($urandom_range(0, 1) == 1) ? 30 : 2;
            if ($urandom_range(0, 99) < 12) m0_cyc_i = ~m0_cyc_i;
            if ($urandom_range(0, 99) < 12) m1_cyc_i = ~m1_cyc_i;
            m0_stb_i = m0_cyc_i && ($urandom_range(0, 99) < 75);
            m1_stb_i = m1_cyc_i && ($urandom_range(0, 99) < 75);
            m0_we_i = 1'($urandom); m0_adr_i = 16'($urandom); m0_dat_i = 16'($urandom);
            m1_we_i = 1'($urandom); m1_adr_i = 16'($urandom); m1_dat_i = 16'($urandom);
            s_dat_i = 16'($urandom);
            s_ack_i = ($urandom_range(0, 99) < ack_pct);
            s_err_i = ($urandom_range(0, 99) < 3);
            #1;
            own = (mdl_cur >= 0) && !mdl_abort;
            exp_v[8:7] = (mdl_cur < 0) ? 2'b00 : ((mdl_cur == 0) ? 2'b01 : 2'b10);
            exp_v[6]   = own && req(mdl_cur);
            exp_v[5]   = own && strobe(mdl_cur);
            exp_v[4]   = own && (mdl_cur == 0) && s_ack_i;
            exp_v[3]   = (mdl_cur == 0) && (mdl_abort || s_err_i);
            exp_v[2]   = own && (mdl_cur == 1) && s_ack_i;
            exp_v[1]   = (mdl_cur == 1) && (mdl_abort || s_err_i);
            exp_v[0]   = mdl_to;
            act_v = {gnt_o, s_cyc_o, s_stb_o, m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, timeout_o};
            checks++; if (act_v !== exp_v) begin
                failures++; $display("FAIL rand_ctrl n=%0d: {gnt,cyc,stb,a0,e0,a1,e1,to} got %b want %b", n, act_v, exp_v);
            end
            if (own) begin
                checks++; if (s_adr_o !== ((mdl_cur == 0) ? m0_adr_i : m1_adr_i) || s_dat_o !== ((mdl_cur == 0) ? m0_dat_i : m1_dat_i)
                              || s_we_o !== ((mdl_cur == 0) ? m0_we_i : m1_we_i)) begin
                    failures++; $display("FAIL rand_route n=%0d: adr=%h dat=%h we=%b, owner %0d", n, s_adr_o, s_dat_o, s_we_o, mdl_cur);
                end
            end
            checks++; if (m0_dat_o !== s_dat_i || m1_dat_o !== s_dat_i) begin
                failures++; $display("FAIL rand_rdata n=%0d: m0=%h m1=%h want %h", n, m0_dat_o, m1_dat_o, s_dat_i);
            end
            tick();
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        test_reset();
        test_single_master();
        test_round_robin();
        test_block_hold();
        test_error_passthrough();
        test_watchdog();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
